// File: rtl/badger_rx_ring.sv
// badger_rx_ring: N-bank receive packet ring.
//
// The MAC writes a frame one byte at a time into the bank selected by the write
// pointer. A frame ending with mac_accept = 1 is queued; the processor reads
// the oldest queued frame as 32-bit words and frees it with cpu_release.
// A frame that starts while the ring is full is dropped and never touches the
// stored banks.
//
// Ports:
//   sysClk, sysReset    clock (rising edge), asynchronous active-high reset
//   mac_wen/a/d         byte write strobe, byte address in frame, byte data
//   mac_end/accept      end-of-frame strobe, keep (1) or reject (0) the frame
//   cpu_raddr/rdata     word index into the head bank, registered read data
//   cpu_release         free the head bank
//   cpu_count           queued frame count
//   cpu_head_len        byte length of the head frame, 0 when empty
//   drop_count          saturating count of dropped frames
//   rx_bytes            accumulated bytes of queued frames (statistics build)
//
// Build option: define RX_RING_STATS_EN to enable rx_bytes and to count
// rejected (mac_accept = 0) frames that carried data as drops.

module badger_rx_ring #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned BANK_WIDTH = 2,
    parameter int unsigned DROP_WIDTH = 16
) (
    input  logic                  sysClk,
    input  logic                  sysReset,
    input  logic                  mac_wen,
    input  logic [ADDR_WIDTH-1:0] mac_a,
    input  logic [7:0]            mac_d,
    input  logic                  mac_end,
    input  logic                  mac_accept,
    input  logic [ADDR_WIDTH-3:0] cpu_raddr,
    output logic [31:0]           cpu_rdata,
    input  logic                  cpu_release,
    output logic [BANK_WIDTH:0]   cpu_count,
    output logic [ADDR_WIDTH:0]   cpu_head_len,
    output logic [DROP_WIDTH-1:0] drop_count,
    output logic [31:0]           rx_bytes
);

    localparam int unsigned NBanks = 1 << BANK_WIDTH;
    // A single-bank ring still needs a 1-bit pointer; it simply stays at 0.
    localparam int unsigned PtrW   = (BANK_WIDTH > 0) ? BANK_WIDTH : 1;
    localparam int unsigned WordW  = ADDR_WIDTH - 2;
    localparam int unsigned IdxW   = PtrW + WordW;
    localparam int unsigned Depth  = NBanks << WordW;

    localparam logic [BANK_WIDTH:0] CountFull = (BANK_WIDTH + 1)'(NBanks);
    localparam logic [PtrW-1:0]     PtrLast   = PtrW'(NBanks - 1);

    // State
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [BANK_WIDTH:0]   count_q, count_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic                  pkt_active_q, pkt_active_d;
    logic                  discard_q, discard_d;
    logic [ADDR_WIDTH:0]   cur_len_q, cur_len_d;
    logic [ADDR_WIDTH:0]   head_len_q, head_len_d;
    logic [31:0]           rdata_q, rdata_d;

    // Storage: four byte lanes plus a per-bank length table (not reset)
    logic [7:0]            lane0_q [Depth];
    logic [7:0]            lane1_q [Depth];
    logic [7:0]            lane2_q [Depth];
    logic [7:0]            lane3_q [Depth];
    logic [ADDR_WIDTH:0]   len_q   [NBanks];

    // Decoded events
    logic                  full;
    logic                  eff_discard;
    logic                  wr_fire;
    logic [ADDR_WIDTH:0]   wr_end_len;
    logic [ADDR_WIDTH:0]   len_now;
    logic                  queue_frame;
    logic                  ring_drop;
    logic                  reject_drop;
    logic                  do_release;
    logic [IdxW-1:0]       wr_idx;
    logic [IdxW-1:0]       rd_idx;

    always_comb begin
        full        = (count_q == CountFull);
        // The drop decision is taken when the frame starts; before the first
        // byte the ring state at this cycle decides it.
        eff_discard = pkt_active_q ? discard_q : full;
        wr_fire     = mac_wen && !eff_discard;
        wr_end_len  = {1'b0, mac_a} + 1'b1;
        // Length includes a byte written in the same cycle as mac_end.
        len_now     = (mac_wen && (wr_end_len > cur_len_q)) ? wr_end_len : cur_len_q;
        queue_frame = mac_end && mac_accept && !eff_discard;
        ring_drop   = mac_end && mac_accept && eff_discard;
`ifdef RX_RING_STATS_EN
        reject_drop = mac_end && !mac_accept && (pkt_active_q || mac_wen);
`else
        reject_drop = 1'b0;
`endif
        do_release  = cpu_release && (count_q != '0);
        wr_idx      = {wr_ptr_q, mac_a[ADDR_WIDTH-1:2]};
        rd_idx      = {rd_ptr_q, cpu_raddr};
    end

    always_comb begin
        pkt_active_d = pkt_active_q;
        discard_d    = discard_q;
        cur_len_d    = len_now;
        if (mac_end) begin
            pkt_active_d = 1'b0;
            discard_d    = 1'b0;
            cur_len_d    = '0;
        end else if (mac_wen && !pkt_active_q) begin
            pkt_active_d = 1'b1;
            discard_d    = full;
        end

        wr_ptr_d = wr_ptr_q;
        if (queue_frame) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end

        rd_ptr_d = rd_ptr_q;
        if (do_release) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (queue_frame && !do_release) begin
            count_d = count_q + 1'b1;
        end else if (!queue_frame && do_release) begin
            count_d = count_q - 1'b1;
        end

        drop_d = drop_q;
        if ((ring_drop || reject_drop) && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end

        head_len_d = (count_q != '0) ? len_q[rd_ptr_q] : '0;
        rdata_d    = {lane3_q[rd_idx], lane2_q[rd_idx], lane1_q[rd_idx], lane0_q[rd_idx]};
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_q       <= '0;
            pkt_active_q <= 1'b0;
            discard_q    <= 1'b0;
            cur_len_q    <= '0;
            head_len_q   <= '0;
            rdata_q      <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
            pkt_active_q <= pkt_active_d;
            discard_q    <= discard_d;
            cur_len_q    <= cur_len_d;
            head_len_q   <= head_len_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memory writes; contents survive reset.
    always_ff @(posedge sysClk) begin
        if (wr_fire) begin
            unique case (mac_a[1:0])
                2'd0: lane0_q[wr_idx] <= mac_d;
                2'd1: lane1_q[wr_idx] <= mac_d;
                2'd2: lane2_q[wr_idx] <= mac_d;
                2'd3: lane3_q[wr_idx] <= mac_d;
                default: ;
            endcase
        end
        if (queue_frame) begin
            len_q[wr_ptr_q] <= len_now;
        end
    end

`ifdef RX_RING_STATS_EN
    logic [31:0] rx_bytes_q, rx_bytes_d;

    always_comb begin
        rx_bytes_d = rx_bytes_q;
        if (queue_frame) begin
            rx_bytes_d = rx_bytes_q + 32'(len_now);
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            rx_bytes_q <= '0;
        end else begin
            rx_bytes_q <= rx_bytes_d;
        end
    end

    assign rx_bytes = rx_bytes_q;
`else
    assign rx_bytes = '0;
`endif

    assign cpu_rdata    = rdata_q;
    assign cpu_count    = count_q;
    assign cpu_head_len = head_len_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_badger_rx_ring.sv
`timescale 1ns/1ps
module tb_badger_rx_ring;

    localparam int AW = 11;
    localparam int BW = 2;
    localparam int DW = 16;
    localparam int NB = 1 << BW;

    logic            sysClk = 1'b0;
    logic            sysReset = 1'b1;
    logic            mac_wen = 1'b0;
    logic [AW-1:0]   mac_a = '0;
    logic [7:0]      mac_d = '0;
    logic            mac_end = 1'b0;
    logic            mac_accept = 1'b0;
    logic [AW-3:0]   cpu_raddr = '0;
    logic [31:0]     cpu_rdata;
    logic            cpu_release = 1'b0;
    logic [BW:0]     cpu_count;
    logic [AW:0]     cpu_head_len;
    logic [DW-1:0]   drop_count;
    logic [31:0]     rx_bytes;

    always #5 sysClk = ~sysClk;

    badger_rx_ring #(
        .ADDR_WIDTH(AW),
        .BANK_WIDTH(BW),
        .DROP_WIDTH(DW)
    ) dut (
        .sysClk      (sysClk),
        .sysReset    (sysReset),
        .mac_wen     (mac_wen),
        .mac_a       (mac_a),
        .mac_d       (mac_d),
        .mac_end     (mac_end),
        .mac_accept  (mac_accept),
        .cpu_raddr   (cpu_raddr),
        .cpu_rdata   (cpu_rdata),
        .cpu_release (cpu_release),
        .cpu_count   (cpu_count),
        .cpu_head_len(cpu_head_len),
        .drop_count  (drop_count),
        .rx_bytes    (rx_bytes)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO of queued frames, each byte = base + address.
    typedef struct {
        int len;
        int base;
    } frame_t;

    frame_t      mq[$];
    int          m_drop = 0;
    logic [31:0] m_bytes = '0;

    typedef struct {
        int pre_rel;
        int len;
        int base;
        bit acc;
        bit rel;
        int exp_count;
        int exp_drop;
        int exp_drop_stats;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic model_drop_inc();
        if (m_drop < (1 << DW) - 1) m_drop++;
    endtask

    task automatic send_frame(input int len, input int base, input bit acc, input bit rel,
                              input bit desc);
        bit full;
        int sz;
        int a;
        full = (mq.size() == NB);
        for (int i = 0; i < len; i++) begin
            a = desc ? (len - 1 - i) : i;
            mac_wen = 1'b1;
            mac_a   = AW'(a);
            mac_d   = 8'(base + a);
            tick();
        end
        mac_wen     = 1'b0;
        mac_end     = 1'b1;
        mac_accept  = acc;
        cpu_release = rel;
        tick();
        mac_end     = 1'b0;
        mac_accept  = 1'b0;
        cpu_release = 1'b0;
        sz = mq.size();
        if (acc && !full) begin
            frame_t f;
            f.len  = len;
            f.base = base;
            mq.push_back(f);
            m_bytes += 32'(len);
        end else if (acc && full) begin
            model_drop_inc();
        end
`ifdef RX_RING_STATS_EN
        if (!acc && len > 0) model_drop_inc();
`endif
        if (rel && sz > 0) mq.delete(0);
    endtask

    task automatic release_one();
        cpu_release = 1'b1;
        tick();
        cpu_release = 1'b0;
        if (mq.size() > 0) mq.delete(0);
    endtask

    task automatic check_state(input string tag);
        int exp_hl;
        int k;
        int b;
        logic [31:0] exp_w;
        tick();
        exp_hl = (mq.size() > 0) ? mq[0].len : 0;
        check({tag, " count"}, 32'(cpu_count), 32'(mq.size()));
        check({tag, " drop"}, 32'(drop_count), 32'(m_drop));
        check({tag, " head_len"}, 32'(cpu_head_len), 32'(exp_hl));
`ifdef RX_RING_STATS_EN
        check({tag, " rx_bytes"}, rx_bytes, m_bytes);
`else
        check({tag, " rx_bytes"}, rx_bytes, 32'd0);
`endif
        if (exp_hl >= 4) begin
            k = $urandom_range(exp_hl / 4 - 1, 0);
            b = mq[0].base;
            cpu_raddr = (AW - 2)'(k);
            tick();
            exp_w = {8'(b + 4 * k + 3), 8'(b + 4 * k + 2), 8'(b + 4 * k + 1), 8'(b + 4 * k)};
            check({tag, " rdata"}, cpu_rdata, exp_w);
        end
    endtask

    initial begin
        int ed;
        tbl[0] = '{0, 17,  8'h20, 1'b1, 1'b0, 2, 0, 0};
        tbl[1] = '{0, 4,   8'h40, 1'b1, 1'b0, 3, 0, 0};
        tbl[2] = '{0, 100, 8'h60, 1'b1, 1'b0, 4, 0, 0};
        tbl[3] = '{0, 33,  8'h80, 1'b1, 1'b0, 4, 1, 1};  // ring full: dropped
        tbl[4] = '{0, 12,  8'ha0, 1'b1, 1'b1, 3, 2, 2};  // release same cycle: still dropped
        tbl[5] = '{0, 9,   8'hc0, 1'b1, 1'b0, 4, 2, 2};
        tbl[6] = '{4, 10,  8'he0, 1'b0, 1'b0, 0, 2, 3};  // rejected frame
        tbl[7] = '{0, 0,   8'h11, 1'b1, 1'b0, 1, 2, 3};  // zero-length frame
        tbl[8] = '{0, 21,  8'h33, 1'b1, 1'b1, 1, 2, 3};

        // Reset state
        tick();
        tick();
        check("reset count", 32'(cpu_count), 32'd0);
        check("reset drop", 32'(drop_count), 32'd0);
        check("reset head_len", 32'(cpu_head_len), 32'd0);
        check("reset rdata", cpu_rdata, 32'd0);
        check("reset rx_bytes", rx_bytes, 32'd0);
        sysReset = 1'b0;
        tick();

        // 64-byte frame, data = address
        send_frame(64, 0, 1'b1, 1'b0, 1'b0);
        tick();
        check("first count", 32'(cpu_count), 32'd1);
        check("first head_len", 32'(cpu_head_len), 32'd64);
        cpu_raddr = 9'd1;
        tick();
        check("first rdata", cpu_rdata, 32'h07060504);

        // Table-driven: fill, overflow, release-vs-drop, reject, zero length
        for (int i = 0; i < 9; i++) begin
            for (int r = 0; r < tbl[i].pre_rel; r++) release_one();
            send_frame(tbl[i].len, tbl[i].base, tbl[i].acc, tbl[i].rel, i[0]);
`ifdef RX_RING_STATS_EN
            ed = tbl[i].exp_drop_stats;
`else
            ed = tbl[i].exp_drop;
`endif
            check_state($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d count const", i), 32'(cpu_count), 32'(tbl[i].exp_count));
            check($sformatf("tbl%0d drop const", i), 32'(drop_count), 32'(ed));
        end

        // Nine frames queued and released one at a time: pointers wrap twice
        while (mq.size() > 0) release_one();
        for (int i = 0; i < 9; i++) begin
            send_frame((i == 4) ? 2048 : 5 + i * 13, 8'h50 + i, 1'b1, 1'b0, i[0]);
            check_state($sformatf("wrap%0d q", i));
            release_one();
            check_state($sformatf("wrap%0d r", i));
        end
        check("wrap empty count", 32'(cpu_count), 32'd0);
        check("wrap empty head_len", 32'(cpu_head_len), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(99, 0);
            if (r < 20) begin
                release_one();
            end else begin
                send_frame((r < 23) ? $urandom_range(2048, 1) : $urandom_range(80, 0),
                           $urandom_range(255, 0), $urandom_range(9, 0) != 0,
                           $urandom_range(4, 0) == 0, $urandom_range(1, 0) == 1);
            end
            check_state($sformatf("rnd%0d", i));
        end

        // Reset mid-frame with two frames queued
        while (mq.size() > 0) release_one();
        send_frame(8, 8'h70, 1'b1, 1'b0, 1'b0);
        send_frame(12, 8'h90, 1'b1, 1'b0, 1'b0);
        check_state("pre-reset");
        for (int i = 0; i < 3; i++) begin
            mac_wen = 1'b1;
            mac_a   = AW'(i);
            mac_d   = 8'(i);
            tick();
        end
        #2 sysReset = 1'b1;
        mac_wen = 1'b0;
        #1;
        check("midreset count", 32'(cpu_count), 32'd0);
        check("midreset drop", 32'(drop_count), 32'd0);
        check("midreset rdata", cpu_rdata, 32'd0);
        mq.delete();
        m_drop  = 0;
        m_bytes = '0;
        tick();
        sysReset = 1'b0;
        tick();
        release_one();
        check_state("empty release");
        send_frame(16, 8'h05, 1'b1, 1'b0, 1'b0);
        check_state("post-reset frame");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/badger_rx_ring.md
Name: badger_rx_ring

Overview:
- Parametrised N-bank receive packet buffer; successor to the fixed two-bank, host-toggled receive buffer in the Badger host-MAC wrapper.
- Accepts the byte-wide MAC write stream and queues completed, accepted frames in a ring of banks.
- Processor reads the oldest frame as 32-bit words, then releases it.
- Single clock domain; callers place CDC outside this block.

Parameters:
- ADDR_WIDTH, 11, log2 of bytes per bank (max frame bytes = 2**ADDR_WIDTH).
- BANK_WIDTH, 2, log2 of bank count (NBANKS = 2**BANK_WIDTH, minimum 1).
- DROP_WIDTH, 16, width of the saturating dropped-frame counter.

Ports:
- sysClk  input  1  clock; all logic on rising edge.
- sysReset  input  1  asynchronous, active-high reset.
- mac_wen  input  1  byte write strobe.
- mac_a  input  ADDR_WIDTH  byte address within the current frame.
- mac_d  input  8  byte data.
- mac_end  input  1  end-of-frame strobe, one cycle.
- mac_accept  input  1  sampled with mac_end: 1 = keep the frame.
- cpu_raddr  input  ADDR_WIDTH-2  word index into the head bank.
- cpu_rdata  output  32  head-bank word; byte address 4k+0 in [7:0], 4k+3 in [31:24].
- cpu_release  input  1  free the head bank (one-cycle strobe).
- cpu_count  output  BANK_WIDTH+1  number of queued frames.
- cpu_head_len  output  ADDR_WIDTH+1  byte length of the head frame; 0 when empty.
- drop_count  output  DROP_WIDTH  saturating count of frames lost to a full ring.
- rx_bytes  output  32  statistics (optional feature); 0 otherwise.

Behaviour:
- Reset values:
  - wr_ptr = rd_ptr = 0; count, drop_count, cpu_rdata, cpu_head_len, rx_bytes = 0.
  - pkt_active = 0; discard = 0; cur_len = 0.
  - Memory contents are not reset.
- Storage:
  - NBANKS × 2**ADDR_WIDTH bytes, organised as four byte lanes of depth NBANKS × 2**(ADDR_WIDTH-2).
  - Lane select = mac_a[1:0]; write word address = {wr_ptr, mac_a[ADDR_WIDTH-1:2]}.
- Frame start:
  - The first mac_wen with pkt_active = 0 sets pkt_active = 1 and latches discard = (count == NBANKS).
  - When discard = 1, all writes of that frame are suppressed, so queued banks are never corrupted.
- Length tracking: on each mac_wen, cur_len <= max(cur_len, mac_a + 1), computed with ADDR_WIDTH+1 bit arithmetic.
- mac_end cycle: clears pkt_active, discard and cur_len. Outcome:
  - mac_accept = 1, discard = 0: len[wr_ptr] <= cur_len (including a same-cycle write); wr_ptr wraps mod NBANKS; count + 1.
  - mac_accept = 1, discard = 1: drop_count + 1, saturating at all-ones.
  - mac_accept = 1 with no bytes written: a zero-length frame is queued.
  - mac_accept = 0: the frame is silently discarded; the bank is reused; no counters change.
- Queue full at mac_end with discard = 0 cannot occur, because discard was latched at frame start while count can only fall in the meantime.
- cpu_release:
  - When count > 0: rd_ptr advances (wraps) and count decrements.
  - When count = 0: ignored.
- Simultaneous accept and release: both pointers advance and count is unchanged. When count == NBANKS this frees a bank for the next frame, not the current one.
- Read path:
  - cpu_rdata <= lanes[{rd_ptr, cpu_raddr}], registered, 1-cycle latency.
  - Reading while empty returns stale data; this is not an error.
- cpu_head_len is registered from len[rd_ptr] when count > 0, else 0. It updates the cycle after any rd_ptr or count change.
- A frame in progress that never sees mac_end is overwritten by the next frame's writes. There is no timeout.

Optional Feature:
- RX_RING_STATS_EN defined:
  - rx_bytes accumulates cur_len of every queued frame, wrapping mod 2**32, reset 0.
  - drop_count also increments on mac_accept = 0 frames that had at least one write (a CRC/filter reject counts as a drop).
- Undefined:
  - rx_bytes is tied to 0.
  - drop_count counts only ring-full drops.

Test Plan:
- Reset, then write bytes 0..63 (data = address) with ADDR_WIDTH = 11 and end with accept -> count = 1, cpu_head_len = 64, cpu_raddr = 1 gives cpu_rdata = 32'h07060504 one cycle later.
- Queue 4 accepted frames (NBANKS = 4), send a fifth -> count stays 4, drop_count = 1, head frame data unchanged.
- Fill the ring, then assert cpu_release on the same cycle as mac_end of a new frame -> that frame is still dropped (drop_count + 1) and count = 3. The next frame is queued and count = 4.
- Frame ending with mac_accept = 0 -> count unchanged, drop_count = 0 (1 with RX_RING_STATS_EN). The next accepted frame lands in the same bank.
- Queue and release 9 frames one at a time -> wr_ptr/rd_ptr wrap twice, each cpu_head_len matches its frame, count returns to 0, cpu_head_len = 0.
- Assert sysReset mid-frame with 2 frames queued -> count = 0, drop_count = 0, and cpu_release on the empty ring keeps count = 0.
